stone_cntr_ctrl: RTL
====================

# stone_cntr_ctrl

Controller that sequences the Stone-Age tally counter on the lab board: conditions raw push-buttons (synchronise, debounce, edge-detect), applies increment/clear commands to a 4-bit count with saturation, and renders the count as a 15-LED tally plus a multiplexed seven-segment readout. Runs entirely on the 100 MHz board clock, using clock enables instead of divided clocks, and replaces the divided-clock counter path in the lab top level.

## Interface
Parameters:
- DB_CYCLES, 1000000: cycles a synchronised button must hold a new level before it is accepted (10 ms at 100 MHz).
- SCAN_BITS, 17: width of the display scan counter; its MSB selects the active digit.
- MAX_CNT, 15: saturation value of the count; must be ≤ 15.

Ports:
- CLK  in  1  board clock, 100 MHz; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- BTN_INC  in  1  raw increment button, asynchronous, active-high.
- BTN_CLR  in  1  raw clear button, asynchronous, active-high.
- count  out  4  current count, binary.
- led  out  15  tally: led[i] = 1 iff i < count.
- full  out  1  high while count == MAX_CNT.
- an  out  4  digit anodes, active-low.
- seg  out  8  segments {dp,g..a}, active-low; dp always 1.

## Operation
- Each button passes a 2-flop synchroniser, then a debouncer FSM:
  - IDLE: accepted level 0. A synced 1 loads the hold counter and moves to PRESS_WAIT.
  - PRESS_WAIT: synced 0 returns to IDLE. After DB_CYCLES consecutive 1s, move to HELD and emit a one-cycle press pulse.
  - HELD: a synced 0 loads the counter and moves to RELEASE_WAIT.
  - RELEASE_WAIT: synced 1 returns to HELD. After DB_CYCLES consecutive 0s, return to IDLE.
- Exactly one press pulse per accepted press, regardless of hold length.
- Count update, priority order:
  - clr pulse: count ← 0.
  - else inc pulse with count < MAX_CNT: count ← count+1.
  - else inc pulse at MAX_CNT: no change (saturate, no wrap).
- Simultaneous clr and inc pulses in the same cycle: clear wins.
- led and full are registered decodes of the next count, so they change on the same edge as count.
- Display: an[0] shows count mod 10, an[1] shows the tens digit. The tens digit is blanked (seg = 8'hFF) when it is 0. an[3:2] are held at 1.

## Timing
- Reset values: count=0, led=0, full=0, an=4'b1111, seg=8'hFF, scan counter=0, both debouncers in IDLE.
- Press latency: BTN rising to press pulse = 2 (sync) + DB_CYCLES cycles. count updates on the following edge. Total = DB_CYCLES+3 edges from the first sampled high.
- Glitch rejection: any bounce shorter than DB_CYCLES produces no pulse.
- Scan: the digit toggles every 2^(SCAN_BITS-1) cycles. an/seg are registered and change together, with no overlapping active anodes.
- RST asserted mid-debounce or mid-scan: everything returns to reset values on the next edge. A button still held after RST deasserts is accepted as a new press after DB_CYCLES.

## Configuration
- SSEG_SCAN_EN defined: scan counter, BCD split and seven-segment decoder are built as described above.
- SSEG_SCAN_EN undefined: scan logic is removed; an is tied to 4'b1111 and seg to 8'hFF permanently. count, led and full are unaffected.

## Structure
- Package stone_pkg holds:
  - debouncer state encodings (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - the 10-entry active-low seven-segment digit constants;
  - the SEG_BLANK constant.
- Sub-module btn_debounce (synchroniser + FSM + hold counter, parameter DB_CYCLES, output press pulse) is instantiated twice.

## Test plan
Simulate with DB_CYCLES=4, SCAN_BITS=3, MAX_CNT=15.
- Reset: hold RST 3 cycles → count=0, led=0, full=0, an=1111, seg=FF.
- Clean press: BTN_INC high for 20 cycles → exactly one increment, 7 edges after the first sampled high. count=1, led=15'h0001.
- Bounce: BTN_INC toggles every 2 cycles for 12 cycles, then stays 0 → count unchanged. A subsequent clean press → count +1.
- Saturation: 17 clean presses → count=15, led=15'h7FFF, full=1. The extra presses are ignored.
- Simultaneous press: BTN_INC and BTN_CLR pressed on the same cycle at count=5 → count=0, full=0.
- Display (SSEG_SCAN_EN defined) at count=12: an alternates 1110/1101 every 4 cycles, with seg=8'hA4 ("2") on an[0] and seg=8'hF9 ("1") on an[1]. At count=3, an[1] shows seg=FF. With the macro undefined, an=1111 and seg=FF throughout.

Source files
------------

// File: rtl/stone_pkg.sv
// Shared constants for the Stone-Age tally counter controller: debouncer
// state encodings and active-low seven-segment patterns ({dp,g..a}).
package stone_pkg;

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] HELD         = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

endpackage

// File: rtl/stone_cntr_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, debounce FSM with a hold counter,
// and a one-cycle press pulse per accepted press. FSM state is in 'state'.
module btn_debounce
   import stone_pkg::*;
#(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   // The cycle that leaves IDLE/HELD already counts as the first stable sample.
   localparam logic [CW-1:0] HOLD_LOAD = CW'(DB_CYCLES - 1);

   logic [1:0]    sync;
   logic [1:0]    state;
   logic [CW-1:0] hold;
   logic          level;

   assign level = sync[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= 2'b00;
         state <= IDLE;
         hold  <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn};
         press <= 1'b0;
         case (state)
            IDLE: begin
               if (level) begin
                  hold  <= HOLD_LOAD;
                  state <= PRESS_WAIT;
               end
            end
            PRESS_WAIT: begin
               if (!level) begin
                  state <= IDLE;
               end else if (hold <= CW'(1)) begin
                  state <= HELD;
                  press <= 1'b1;
               end else begin
                  hold <= hold - CW'(1);
               end
            end
            HELD: begin
               if (!level) begin
                  hold  <= HOLD_LOAD;
                  state <= RELEASE_WAIT;
               end
            end
            RELEASE_WAIT: begin
               if (level) begin
                  state <= HELD;
               end else if (hold <= CW'(1)) begin
                  state <= IDLE;
               end else begin
                  hold <= hold - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/stone_cntr_ctrl.sv
// Tally counter controller: debounced inc/clr buttons drive a saturating
// 4-bit count, LED tally and (with SSEG_SCAN_EN) a 2-digit multiplexed display.
module stone_cntr_ctrl
   import stone_pkg::*;
#(
   parameter int DB_CYCLES = 1000000,
   parameter int SCAN_BITS = 17,
   parameter int MAX_CNT   = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        BTN_INC,
   input  logic        BTN_CLR,
   output logic [3:0]  count,
   output logic [14:0] led,
   output logic        full,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   localparam logic [3:0] MAX4 = 4'(MAX_CNT);

   logic        inc_pulse;
   logic        clr_pulse;
   logic [3:0]  next_count;
   logic [14:0] next_led;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc (
      .clk   (CLK),
      .rst   (RST),
      .btn   (BTN_INC),
      .press (inc_pulse)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (
      .clk   (CLK),
      .rst   (RST),
      .btn   (BTN_CLR),
      .press (clr_pulse)
   );

   // Clear has priority over increment; increment saturates at MAX_CNT.
   always_comb begin
      next_count = count;
      if (clr_pulse) begin
         next_count = 4'd0;
      end else if (inc_pulse && (count < MAX4)) begin
         next_count = count + 4'd1;
      end
      next_led = '0;
      for (int i = 0; i < 15; i++) begin
         next_led[i] = (4'(i) < next_count);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count <= 4'd0;
         led   <= '0;
         full  <= 1'b0;
      end else begin
         count <= next_count;
         led   <= next_led;
         full  <= (next_count == MAX4);
      end
   end

`ifdef SSEG_SCAN_EN
   logic [SCAN_BITS-1:0] scan;
   logic                 tens;
   logic [3:0]           ones;
   logic [3:0]           an_next;
   logic [7:0]           seg_next;

   always_comb begin
      tens = (count >= 4'd10);
      ones = tens ? (count - 4'd10) : count;
      if (scan[SCAN_BITS-1]) begin
         an_next  = 4'b1101;
         seg_next = tens ? SEG_DIGIT[1] : SEG_BLANK;
      end else begin
         an_next  = 4'b1110;
         seg_next = SEG_DIGIT[ones];
      end
   end

   // an and seg share one register stage so a digit never shows the other's pattern.
   always_ff @(posedge CLK) begin
      if (RST) begin
         scan <= '0;
         an   <= 4'b1111;
         seg  <= SEG_BLANK;
      end else begin
         scan <= scan + 1'b1;
         an   <= an_next;
         seg  <= seg_next;
      end
   end
`else
   // SCAN_BITS has no effect without the scanner; it is only referenced here.
   localparam logic [7:0] SEG_OFF = (SCAN_BITS > 0) ? SEG_BLANK : SEG_BLANK;

   assign an  = 4'b1111;
   assign seg = SEG_OFF;
`endif

endmodule
